// File: rtl/mcl_mem_pkg.sv
// Shared types and the cycle-type decode for the MCL memory-cycle sequencer.
package mcl_mem_pkg;

  // Microcode memory request function, encoded as it arrives on mem_func_h.
  typedef enum logic [1:0] {
    MEM_READ  = 2'b00,
    MEM_WRITE = 2'b01,
    MEM_RPW   = 2'b10,
    MEM_FETCH = 2'b11
  } mem_func_t;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_REQ       = 3'd1,
    ST_WAIT_DATA = 3'd2,
    ST_LOAD      = 3'd3,
    ST_PAUSED    = 3'd4
  } mcl_seq_state_t;

  // Active-high cycle-type qualifiers; the top inverts the active-low ones.
  typedef struct packed {
    logic rd;
    logic wr;
    logic fetch;
  } cyc_type_t;

  // A fetch is an instruction read, so it raises read as well as fetch.
  // The read half of an RPW is a plain read; the pause is tracked separately.
  function automatic cyc_type_t decode_cyc_type(input mem_func_t func);
    cyc_type_t ct;
    ct = '{rd: 1'b0, wr: 1'b0, fetch: 1'b0};
    case (func)
      MEM_READ:  ct.rd = 1'b1;
      MEM_WRITE: ct.wr = 1'b1;
      MEM_RPW:   ct.rd = 1'b1;
      MEM_FETCH: begin
        ct.rd    = 1'b1;
        ct.fetch = 1'b1;
      end
      default:   ct = '{rd: 1'b0, wr: 1'b0, fetch: 1'b0};
    endcase
    return ct;
  endfunction

endpackage

// File: rtl/mcl_mem_timeout.sv
// Loadable 8-bit cycle counter with a terminal-count compare, used to abort
// a memory cycle that the MBOX never finishes.
module mcl_mem_timeout #(
  parameter int unsigned TERM_COUNT = 32'd63
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic inc,
  output logic term
);

  logic [7:0] count_r;

  // Count cycles since the last load; a load always wins over increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= 8'd0;
    end else if (load) begin
      count_r <= 8'd0;
    end else if (inc) begin
      count_r <= count_r + 8'd1;
    end else begin
      count_r <= count_r;
    end
  end

  assign term = (count_r == 8'(TERM_COUNT - 32'd1));

endmodule

// File: rtl/mcl_mem_cycle_seq.sv
// EBOX memory-cycle sequencer: issues one MBOX cycle at a time, tracks ack,
// data return, page fail and timeout, and drives the AR strobes and stall.
// Every output is a flop loaded from the next-state decode.
module mcl_mem_cycle_seq
  import mcl_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 32'd63
) (
  input  logic       clk3_mcl_h,
  input  logic       mr_reset_04_h,
  input  logic       mem_go_h,
  input  logic [1:0] mem_func_h,
  input  logic       vma_user_h,
  input  logic       mbox_cyc_ack_h,
  input  logic       mbox_data_valid_h,
  input  logic       mbox_page_fail_h,
  output logic       mcl_mbox_cyc_req_h,
  output logic       mcl2_vma_read_l,
  output logic       mcl2_vma_write_l,
  output logic       mcl2_vma_pause_h,
  output logic       mcl6_vma_fetch_h,
  output logic       mcl_vma_user_h,
  output logic       mcl_load_ar_h,
  output logic       mcl_store_ar_l,
  output logic       mem_stall_h,
  output logic       mem_page_fail_h,
  output logic       mem_timeout_h,
  output logic       seq_err_h
);

  mcl_seq_state_t state_r, state_nxt_s;
  mem_func_t      func_r, func_nxt_s;
  cyc_type_t      ct_nxt_s;
  logic user_r, user_nxt_s;
  logic pause_r, pause_nxt_s;
  logic seq_err_r;
  logic capture_s, pf_s, to_s, err_s, tc_s, active_nxt_s, count_inc_s;
  logic req_r, rd_l_r, wr_l_r, fetch_r, user_out_r, load_r, store_l_r;
  logic stall_r, pf_r, to_r;

  assign count_inc_s = (state_r == ST_REQ) || (state_r == ST_WAIT_DATA);

  mcl_mem_timeout #(
    .TERM_COUNT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk  (clk3_mcl_h),
    .rst  (mr_reset_04_h),
    .load (capture_s),
    .inc  (count_inc_s),
    .term (tc_s)
  );

  // Next-state decode; abort priority is page fail, then completion, then timeout.
  always_comb begin
    state_nxt_s = state_r;
    capture_s   = 1'b0;
    pause_nxt_s = pause_r;
    pf_s        = 1'b0;
    to_s        = 1'b0;
    err_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (mem_go_h) begin
          state_nxt_s = ST_REQ;
          capture_s   = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        err_s = mem_go_h;
        if (mbox_page_fail_h) begin
          state_nxt_s = ST_IDLE;
          pause_nxt_s = 1'b0;
          pf_s        = 1'b1;
        end else if (mbox_cyc_ack_h && (func_r == MEM_WRITE)) begin
          state_nxt_s = ST_IDLE;
          pause_nxt_s = 1'b0;
        end else if (mbox_cyc_ack_h && mbox_data_valid_h) begin
          state_nxt_s = ST_LOAD;
        end else if (tc_s) begin
          state_nxt_s = ST_IDLE;
          pause_nxt_s = 1'b0;
          to_s        = 1'b1;
        end else if (mbox_cyc_ack_h) begin
          state_nxt_s = ST_WAIT_DATA;
        end else begin
          state_nxt_s = ST_REQ;
        end
      end
      ST_WAIT_DATA: begin
        err_s = mem_go_h;
        if (mbox_page_fail_h) begin
          state_nxt_s = ST_IDLE;
          pause_nxt_s = 1'b0;
          pf_s        = 1'b1;
        end else if (mbox_data_valid_h) begin
          state_nxt_s = ST_LOAD;
        end else if (tc_s) begin
          state_nxt_s = ST_IDLE;
          pause_nxt_s = 1'b0;
          to_s        = 1'b1;
        end else begin
          state_nxt_s = ST_WAIT_DATA;
        end
      end
      ST_LOAD: begin
        err_s = mem_go_h;
        if (func_r == MEM_RPW) begin
          state_nxt_s = ST_PAUSED;
          pause_nxt_s = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_PAUSED: begin
        // Only the write half of the RPW may follow the read half.
        if (mem_go_h && (mem_func_h == MEM_WRITE)) begin
          state_nxt_s = ST_REQ;
          capture_s   = 1'b1;
        end else if (mem_go_h) begin
          state_nxt_s = ST_PAUSED;
          err_s       = 1'b1;
        end else begin
          state_nxt_s = ST_PAUSED;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        pause_nxt_s = 1'b0;
      end
    endcase
    func_nxt_s   = capture_s ? mem_func_t'(mem_func_h) : func_r;
    user_nxt_s   = capture_s ? vma_user_h : user_r;
    ct_nxt_s     = decode_cyc_type(func_nxt_s);
    active_nxt_s = (state_nxt_s == ST_REQ) || (state_nxt_s == ST_WAIT_DATA);
  end

  // State, captured cycle type and registered outputs.
  always_ff @(posedge clk3_mcl_h) begin
    if (mr_reset_04_h) begin
      state_r    <= ST_IDLE;
      func_r     <= MEM_READ;
      user_r     <= 1'b0;
      pause_r    <= 1'b0;
      seq_err_r  <= 1'b0;
      req_r      <= 1'b0;
      rd_l_r     <= 1'b1;
      wr_l_r     <= 1'b1;
      fetch_r    <= 1'b0;
      user_out_r <= 1'b0;
      load_r     <= 1'b0;
      store_l_r  <= 1'b1;
      stall_r    <= 1'b0;
      pf_r       <= 1'b0;
      to_r       <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      func_r     <= func_nxt_s;
      user_r     <= user_nxt_s;
      pause_r    <= pause_nxt_s;
      seq_err_r  <= seq_err_r | err_s;
      req_r      <= (state_nxt_s == ST_REQ);
      rd_l_r     <= ~(active_nxt_s & ct_nxt_s.rd);
      wr_l_r     <= ~(active_nxt_s & ct_nxt_s.wr);
      fetch_r    <= active_nxt_s & ct_nxt_s.fetch;
      user_out_r <= active_nxt_s & user_nxt_s;
      load_r     <= (state_nxt_s == ST_LOAD);
      store_l_r  <= ~((state_nxt_s == ST_REQ) & ct_nxt_s.wr);
      stall_r    <= active_nxt_s || (state_nxt_s == ST_LOAD);
      pf_r       <= pf_s;
      to_r       <= to_s;
    end
  end

  assign mcl_mbox_cyc_req_h = req_r;
  assign mcl2_vma_read_l    = rd_l_r;
  assign mcl2_vma_write_l   = wr_l_r;
  assign mcl2_vma_pause_h   = pause_r;
  assign mcl6_vma_fetch_h   = fetch_r;
  assign mcl_vma_user_h     = user_out_r;
  assign mcl_load_ar_h      = load_r;
  assign mcl_store_ar_l     = store_l_r;
  assign mem_stall_h        = stall_r;
  assign mem_page_fail_h    = pf_r;
  assign mem_timeout_h      = to_r;
  assign seq_err_h          = seq_err_r;

endmodule

// File: tb/tb_mcl_mem_cycle_seq.sv
// Bench for mcl_mem_cycle_seq: directed sequences with hand-computed output
// vectors, plus an event scoreboard for load/page-fail/timeout pulses.
module tb_mcl_mem_cycle_seq;

  logic clk3_mcl_h = 1'b0;
  logic mr_reset_04_h, mem_go_h, go_t, vma_user_h;
  logic [1:0] mem_func_h;
  logic mbox_cyc_ack_h, mbox_data_valid_h, mbox_page_fail_h;

  logic a_req, a_rdl, a_wrl, a_pause, a_fetch, a_user, a_load, a_stl, a_stall, a_pf, a_to, a_err;
  logic t_req, t_rdl, t_wrl, t_pause, t_fetch, t_user, t_load, t_stl, t_stall, t_pf, t_to, t_err;
  logic [11:0] obs_a, obs_t;

  int n_checks = 0;
  int n_err    = 0;

  // Expected pulse events per DUT, encoded {timeout, page_fail, load}.
  logic [2:0] exp_q_a[$];
  logic [2:0] exp_q_t[$];

  always #5 clk3_mcl_h = ~clk3_mcl_h;

  mcl_mem_cycle_seq dut_a (
    .clk3_mcl_h(clk3_mcl_h), .mr_reset_04_h(mr_reset_04_h), .mem_go_h(mem_go_h),
    .mem_func_h(mem_func_h), .vma_user_h(vma_user_h), .mbox_cyc_ack_h(mbox_cyc_ack_h),
    .mbox_data_valid_h(mbox_data_valid_h), .mbox_page_fail_h(mbox_page_fail_h),
    .mcl_mbox_cyc_req_h(a_req), .mcl2_vma_read_l(a_rdl), .mcl2_vma_write_l(a_wrl),
    .mcl2_vma_pause_h(a_pause), .mcl6_vma_fetch_h(a_fetch), .mcl_vma_user_h(a_user),
    .mcl_load_ar_h(a_load), .mcl_store_ar_l(a_stl), .mem_stall_h(a_stall),
    .mem_page_fail_h(a_pf), .mem_timeout_h(a_to), .seq_err_h(a_err)
  );

  mcl_mem_cycle_seq #(.TIMEOUT_CYCLES(32'd4)) dut_t (
    .clk3_mcl_h(clk3_mcl_h), .mr_reset_04_h(mr_reset_04_h), .mem_go_h(go_t),
    .mem_func_h(mem_func_h), .vma_user_h(vma_user_h), .mbox_cyc_ack_h(mbox_cyc_ack_h),
    .mbox_data_valid_h(mbox_data_valid_h), .mbox_page_fail_h(mbox_page_fail_h),
    .mcl_mbox_cyc_req_h(t_req), .mcl2_vma_read_l(t_rdl), .mcl2_vma_write_l(t_wrl),
    .mcl2_vma_pause_h(t_pause), .mcl6_vma_fetch_h(t_fetch), .mcl_vma_user_h(t_user),
    .mcl_load_ar_h(t_load), .mcl_store_ar_l(t_stl), .mem_stall_h(t_stall),
    .mem_page_fail_h(t_pf), .mem_timeout_h(t_to), .seq_err_h(t_err)
  );

  assign obs_a = {a_req, a_rdl, a_wrl, a_pause, a_fetch, a_user, a_load, a_stl, a_stall, a_pf, a_to, a_err};
  assign obs_t = {t_req, t_rdl, t_wrl, t_pause, t_fetch, t_user, t_load, t_stl, t_stall, t_pf, t_to, t_err};

  // Expected output vector in the same bit order as obs_a/obs_t.
  function automatic logic [11:0] v(input logic req, input logic rdl, input logic wrl,
                                    input logic pause, input logic fetch, input logic user,
                                    input logic load, input logic stl, input logic stall,
                                    input logic pf, input logic to, input logic err);
    return {req, rdl, wrl, pause, fetch, user, load, stl, stall, pf, to, err};
  endfunction

  task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b (req rdl wrl pause fetch user load stl stall pf to err)",
               name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk3_mcl_h);
    #1;
  endtask

  // Monitor: every pulse presented by a DUT must match the next queued event.
  always @(negedge clk3_mcl_h) begin
    logic [2:0] obs, e;
    obs = {a_to, a_pf, a_load};
    if (obs != 3'b000) begin
      n_checks++;
      if (exp_q_a.size() == 0) begin
        n_err++;
        $display("FAIL evt_a: got %b expected no event", obs);
      end else begin
        e = exp_q_a.pop_front();
        if (obs !== e) begin
          n_err++;
          $display("FAIL evt_a: got %b expected %b", obs, e);
        end
      end
    end
    obs = {t_to, t_pf, t_load};
    if (obs != 3'b000) begin
      n_checks++;
      if (exp_q_t.size() == 0) begin
        n_err++;
        $display("FAIL evt_t: got %b expected no event", obs);
      end else begin
        e = exp_q_t.pop_front();
        if (obs !== e) begin
          n_err++;
          $display("FAIL evt_t: got %b expected %b", obs, e);
        end
      end
    end
  end

  initial begin
    logic [11:0] idle_v;
    idle_v = v(1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0);
    mr_reset_04_h = 1'b1; mem_go_h = 1'b0; go_t = 1'b0; mem_func_h = 2'b00; vma_user_h = 1'b0;
    mbox_cyc_ack_h = 1'b0; mbox_data_valid_h = 1'b0; mbox_page_fail_h = 1'b0;
    cyc(); cyc();
    chk("reset_a", obs_a, idle_v);
    chk("reset_t", obs_t, idle_v);
    mr_reset_04_h = 1'b0;

    // Read: ack on third REQ cycle, data on third WAIT_DATA cycle.
    mem_go_h = 1'b1; mem_func_h = 2'b00; vma_user_h = 1'b1;
    cyc(); mem_go_h = 1'b0; vma_user_h = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("rd_req", obs_a, v(1'b1,1'b0,1'b1,1'b0,1'b0,1'b1,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0));
      if (i == 2) mbox_cyc_ack_h = 1'b1;
      cyc();
    end
    mbox_cyc_ack_h = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("rd_wait", obs_a, v(1'b0,1'b0,1'b1,1'b0,1'b0,1'b1,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0));
      if (i == 2) begin
        mbox_data_valid_h = 1'b1;
        exp_q_a.push_back(3'b001);
      end
      cyc();
    end
    mbox_data_valid_h = 1'b0;
    chk("rd_load", obs_a, v(1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b1,1'b1,1'b1,1'b0,1'b0,1'b0));
    cyc();
    chk("rd_idle", obs_a, idle_v);

    // RPW: ack and data together, pause, then write half.
    mem_go_h = 1'b1; mem_func_h = 2'b10;
    cyc(); mem_go_h = 1'b0;
    chk("rpw_req", obs_a, v(1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0));
    mbox_cyc_ack_h = 1'b1; mbox_data_valid_h = 1'b1; exp_q_a.push_back(3'b001);
    cyc(); mbox_cyc_ack_h = 1'b0; mbox_data_valid_h = 1'b0;
    chk("rpw_load", obs_a, v(1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b1,1'b1,1'b1,1'b0,1'b0,1'b0));
    cyc();
    chk("rpw_paused1", obs_a, v(1'b0,1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0));
    cyc();
    chk("rpw_paused2", obs_a, v(1'b0,1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0));
    mem_go_h = 1'b1; mem_func_h = 2'b01;
    cyc(); mem_go_h = 1'b0;
    chk("rpw_wreq", obs_a, v(1'b1,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0));
    mbox_cyc_ack_h = 1'b1;
    cyc(); mbox_cyc_ack_h = 1'b0;
    chk("rpw_done", obs_a, idle_v);

    // Page fail together with ack wins; no load strobe.
    mem_go_h = 1'b1; mem_func_h = 2'b00;
    cyc(); mem_go_h = 1'b0;
    mbox_cyc_ack_h = 1'b1; mbox_page_fail_h = 1'b1; exp_q_a.push_back(3'b010);
    cyc(); mbox_cyc_ack_h = 1'b0; mbox_page_fail_h = 1'b0;
    chk("pf_pulse", obs_a, v(1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0));
    cyc();
    chk("pf_idle", obs_a, idle_v);

    // Illegal go during WAIT_DATA: flag set, cycle continues.
    mem_go_h = 1'b1; mem_func_h = 2'b00;
    cyc(); mem_go_h = 1'b0;
    mbox_cyc_ack_h = 1'b1;
    cyc(); mbox_cyc_ack_h = 1'b0;
    mem_go_h = 1'b1; mem_func_h = 2'b01;
    cyc(); mem_go_h = 1'b0;
    chk("err_wait", obs_a, v(1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b1));
    mbox_data_valid_h = 1'b1; exp_q_a.push_back(3'b001);
    cyc(); mbox_data_valid_h = 1'b0;
    chk("err_load", obs_a, v(1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b1,1'b1,1'b1,1'b0,1'b0,1'b1));
    cyc();
    chk("err_sticky", obs_a, v(1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b1));
    mr_reset_04_h = 1'b1;
    cyc(); mr_reset_04_h = 1'b0;
    chk("err_reset1", obs_a, idle_v);

    // Illegal read go while PAUSED: stays paused, flag set.
    mem_go_h = 1'b1; mem_func_h = 2'b10;
    cyc(); mem_go_h = 1'b0;
    mbox_cyc_ack_h = 1'b1; mbox_data_valid_h = 1'b1; exp_q_a.push_back(3'b001);
    cyc(); mbox_cyc_ack_h = 1'b0; mbox_data_valid_h = 1'b0;
    cyc();
    mem_go_h = 1'b1; mem_func_h = 2'b00;
    cyc(); mem_go_h = 1'b0;
    chk("err_paused", obs_a, v(1'b0,1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b1));
    mem_go_h = 1'b1; mem_func_h = 2'b01;
    cyc(); mem_go_h = 1'b0;
    chk("err_wreq", obs_a, v(1'b1,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b1));
    mbox_cyc_ack_h = 1'b1;
    cyc(); mbox_cyc_ack_h = 1'b0;
    chk("err_wdone", obs_a, v(1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b1));
    mr_reset_04_h = 1'b1;
    cyc(); mr_reset_04_h = 1'b0;
    chk("err_reset2", obs_a, idle_v);

    // Reset in WAIT_DATA, then stale data valid is ignored.
    mem_go_h = 1'b1; mem_func_h = 2'b00; vma_user_h = 1'b1;
    cyc(); mem_go_h = 1'b0; vma_user_h = 1'b0;
    mbox_cyc_ack_h = 1'b1;
    cyc(); mbox_cyc_ack_h = 1'b0;
    chk("rst_wait", obs_a, v(1'b0,1'b0,1'b1,1'b0,1'b0,1'b1,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0));
    mr_reset_04_h = 1'b1;
    cyc(); mr_reset_04_h = 1'b0;
    chk("rst_mid", obs_a, idle_v);
    mbox_data_valid_h = 1'b1;
    cyc(); mbox_data_valid_h = 1'b0;
    chk("rst_stale", obs_a, idle_v);
    cyc();
    chk("rst_idle", obs_a, idle_v);

    // Timeout on the short-timeout instance: fetch with no ack.
    go_t = 1'b1; mem_func_h = 2'b11;
    cyc(); go_t = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("to_req", obs_t, v(1'b1,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0));
      if (i == 3) exp_q_t.push_back(3'b100);
      cyc();
    end
    chk("to_pulse", obs_t, v(1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b1,1'b0));
    cyc();
    chk("to_idle", obs_t, idle_v);
    chk("to_a_idle", obs_a, idle_v);

    @(negedge clk3_mcl_h);
    #1;
    n_checks++;
    if (exp_q_a.size() != 0) begin
      n_err++;
      $display("FAIL evt_a_left: got %0d pending events expected 0", exp_q_a.size());
    end
    n_checks++;
    if (exp_q_t.size() != 0) begin
      n_err++;
      $display("FAIL evt_t_left: got %0d pending events expected 0", exp_q_t.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
